// File: rtl/dco_tune_pkg.sv
// dco_tune_pkg
//   Shared definitions for the DCO capacitor-bank tuning sequencer.
//   - state_t        : sequencer FSM states
//   - DEF_*          : default parameter values
//   - therm_w()      : thermometer width for a W-bit binary code (2**W-1)
package dco_tune_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STEP   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam int DEF_W          = 6;
    localparam int DEF_MAX_STEP   = 4;
    localparam int DEF_DIV        = 4;
    localparam int DEF_SETTLE_CYC = 8;
    localparam int DEF_RESET_CODE = 32;

    function automatic int therm_w(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/dco_bin2therm.sv
// dco_bin2therm
//   Combinational binary-to-thermometer decoder for the DCO bank.
//   Ports:
//     i_code  [W-1:0]           binary bank code
//     o_therm [2**W-2:0]        thermometer code, bit k = (k < i_code)
module dco_bin2therm
    import dco_tune_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0]          i_code,
    output logic [therm_w(W)-1:0] o_therm
);

    always_comb begin
        o_therm = '0;
        for (int k = 0; k < therm_w(W); k++) begin
            o_therm[k] = (W'(k) < i_code);
        end
    end

endmodule

// File: rtl/dco_tune_sequencer.sv
// dco_tune_sequencer
//   Rate-limited walker for the ADPLL thermometer-coded DCO capacitor bank.
//   A target word is accepted in IDLE, then the bank code moves toward it by
//   at most MAX_STEP per update. Each update is preceded by DIV cycles in STEP
//   and followed by SETTLE_CYC cycles in SETTLE, so the bank decoder never
//   sees a large simultaneous switching event.
//
//   Handshake: a target transfers on a rising edge where tgt_valid_i and
//   tgt_ready_o are both high. tgt_ready_o is high only in IDLE and does not
//   depend on tgt_valid_i; the source holds tgt_valid_i and tgt_i stable
//   until the transfer.
//
//   Ports:
//     clk, rst       clock (rising edge), asynchronous active-high reset
//     tgt_i          target tuning word           tgt_valid_i / tgt_ready_o
//     freeze_i       pauses STEP/SETTLE counters; code held
//     code_o         registered binary bank code
//     therm_o        registered thermometer code of code_o
//     busy_o         high in STEP or SETTLE
//     done_o         one-cycle pulse when code_o reaches the accepted target
//     dbg_state_o    current FSM state
module dco_tune_sequencer
    import dco_tune_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int MAX_STEP   = DEF_MAX_STEP,
    parameter int DIV        = DEF_DIV,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int RESET_CODE = DEF_RESET_CODE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          tgt_i,
    input  logic                  tgt_valid_i,
    output logic                  tgt_ready_o,
    input  logic                  freeze_i,
    output logic [W-1:0]          code_o,
    output logic [therm_w(W)-1:0] therm_o,
    output logic                  busy_o,
    output logic                  done_o,
    output state_t                dbg_state_o
);

    localparam int TW    = therm_w(W);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [W-1:0]     RST_CODE = W'(RESET_CODE);
    localparam logic [W:0]       MAX_STEP_X = (W+1)'(MAX_STEP);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [W-1:0]     r_code;
    logic [TW-1:0]    r_therm;
    logic [W-1:0]     r_tgt;
    logic             r_done;
    logic [DIV_W-1:0] r_div_cnt;
    logic [SET_W-1:0] r_set_cnt;

    logic [DIV_W-1:0] w_div_nxt;
    logic [SET_W-1:0] w_set_nxt;
    logic             w_load_tgt;
    logic             w_do_step;
    logic             w_done_nxt;

    logic [W:0]       w_diff;
    logic [W:0]       w_mag;
    logic [W:0]       w_step;
    logic [W-1:0]     w_code_step;
    logic [TW-1:0]    w_therm_step;
    logic [TW-1:0]    w_therm_rst;

    // Signed W+1-bit difference; its magnitude never exceeds 2**W-1, so the
    // clamped step always keeps the code inside 0..2**W-1.
    always_comb begin
        w_diff = {1'b0, r_tgt} - {1'b0, r_code};
        w_mag  = w_diff[W] ? (~w_diff + 1'b1) : w_diff;
        w_step = (w_mag > MAX_STEP_X) ? MAX_STEP_X : w_mag;
        w_code_step = w_diff[W] ? (r_code - w_step[W-1:0])
                                : (r_code + w_step[W-1:0]);
    end

    dco_bin2therm #(.W(W)) u_b2t_step (
        .i_code  (w_code_step),
        .o_therm (w_therm_step)
    );

    // Constant input: folds to the reset thermometer pattern.
    dco_bin2therm #(.W(W)) u_b2t_rst (
        .i_code  (RST_CODE),
        .o_therm (w_therm_rst)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div_cnt;
        w_set_nxt   = r_set_cnt;
        w_load_tgt  = 1'b0;
        w_do_step   = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Accept is independent of freeze_i; stepping waits instead.
                if (tgt_valid_i) begin
                    w_load_tgt = 1'b1;
                    if (tgt_i == r_code) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_STEP;
                        w_div_nxt   = '0;
                    end
                end
            end
            ST_STEP: begin
                if (!freeze_i) begin
                    if (r_div_cnt == DIV_LAST) begin
                        w_do_step   = 1'b1;
                        w_state_nxt = ST_SETTLE;
                        w_set_nxt   = '0;
                    end else begin
                        w_div_nxt = r_div_cnt + 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (!freeze_i) begin
                    if (r_set_cnt == SET_LAST) begin
                        w_set_nxt = '0;
                        if (r_code == r_tgt) begin
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = ST_STEP;
                            w_div_nxt   = '0;
                        end
                    end else begin
                        w_set_nxt = r_set_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code    <= RST_CODE;
            r_therm   <= w_therm_rst;
            r_tgt     <= RST_CODE;
            r_done    <= 1'b0;
            r_div_cnt <= '0;
            r_set_cnt <= '0;
        end else begin
            r_done    <= w_done_nxt;
            r_div_cnt <= w_div_nxt;
            r_set_cnt <= w_set_nxt;
            if (w_load_tgt) begin
                r_tgt <= tgt_i;
            end
            // Code and thermometer move on the same edge, never apart.
            if (w_do_step) begin
                r_code  <= w_code_step;
                r_therm <= w_therm_step;
            end
        end
    end

    assign code_o      = r_code;
    assign therm_o     = r_therm;
    assign done_o      = r_done;
    assign tgt_ready_o = (r_state == ST_IDLE);
    assign busy_o      = (r_state == ST_STEP) || (r_state == ST_SETTLE);
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_dco_tune_sequencer.sv
// tb_dco_tune_sequencer
//   Directed bench for dco_tune_sequencer with default parameters
//   (W=6, MAX_STEP=4, DIV=4, SETTLE_CYC=8, RESET_CODE=32).
//   Index k in a captured trace is the sample taken 1 time unit after the
//   k-th rising edge following the accept edge (index 0 = just after it).
module tb_dco_tune_sequencer;
    import dco_tune_pkg::*;

    localparam int W  = 6;
    localparam int TW = 63;

    logic          clk;
    logic          rst;
    logic [W-1:0]  tgt_i;
    logic          tgt_valid_i;
    logic          tgt_ready_o;
    logic          freeze_i;
    logic [W-1:0]  code_o;
    logic [TW-1:0] therm_o;
    logic          busy_o;
    logic          done_o;
    state_t        dbg_state_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0]  c_code  [0:127];
    logic [TW-1:0] c_therm [0:127];
    logic          c_done  [0:127];
    logic          c_ready [0:127];
    logic          c_busy  [0:127];

    dco_tune_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .tgt_i       (tgt_i),
        .tgt_valid_i (tgt_valid_i),
        .tgt_ready_o (tgt_ready_o),
        .freeze_i    (freeze_i),
        .code_o      (code_o),
        .therm_o     (therm_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a target and return just after the edge that transfers it.
    task automatic accept(input logic [W-1:0] v);
        tgt_i       = v;
        tgt_valid_i = 1'b1;
        for (int n = 0; n < 200 && !tgt_ready_o; n++) tick();
        if (!tgt_ready_o) check("ready_timeout", 64'(tgt_ready_o), 64'd1);
        tick();
        tgt_valid_i = 1'b0;
    endtask

    // Record outputs for indices 0..len; freeze_i is high while driving the
    // edges that follow samples fs..fs+fl-1.
    task automatic capture(input int len, input int fs, input int fl);
        for (int i = 0; i <= len; i++) begin
            c_code[i]  = code_o;
            c_therm[i] = therm_o;
            c_done[i]  = done_o;
            c_ready[i] = tgt_ready_o;
            c_busy[i]  = busy_o;
            if (i < len) begin
                freeze_i = (i >= fs) && (i < fs + fl);
                tick();
            end
        end
        freeze_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst         = 1'b1;
        tgt_i       = '0;
        tgt_valid_i = 1'b0;
        freeze_i    = 1'b0;
        tick();
        tick();
        check("rst_code",  64'(code_o), 64'd32);
        check("rst_therm", 64'(therm_o), 64'h0000_0000_FFFF_FFFF);
        check("rst_ready", 64'(tgt_ready_o), 64'd1);
        check("rst_busy",  64'(busy_o), 64'd0);
        check("rst_done",  64'(done_o), 64'd0);
        rst = 1'b0;
        tick();
        tick();
        check("idle_code",  64'(code_o), 64'd32);
        check("idle_ready", 64'(tgt_ready_o), 64'd1);

        // Equal target: done for exactly one cycle, never busy.
        accept(6'd32);
        check("eq_done0", 64'(done_o), 64'd1);
        check("eq_busy0", 64'(busy_o), 64'd0);
        check("eq_ready0", 64'(tgt_ready_o), 64'd1);
        tick();
        check("eq_done1", 64'(done_o), 64'd0);
        check("eq_code1", 64'(code_o), 64'd32);

        // 32 -> 30: one step at index 4, done at 12.
        accept(6'd30);
        capture(13, -1, 0);
        check("dn_busy0",  64'(c_busy[0]), 64'd1);
        check("dn_ready0", 64'(c_ready[0]), 64'd0);
        check("dn_code3",  64'(c_code[3]), 64'd32);
        check("dn_code4",  64'(c_code[4]), 64'd30);
        check("dn_therm4", 64'(c_therm[4]), 64'h0000_0000_3FFF_FFFF);
        check("dn_done11", 64'(c_done[11]), 64'd0);
        check("dn_done12", 64'(c_done[12]), 64'd1);
        check("dn_ready12", 64'(c_ready[12]), 64'd1);
        check("dn_done13", 64'(c_done[13]), 64'd0);

        // 30 -> 32 with a second target (41) held valid during the walk.
        accept(6'd32);
        tgt_i       = 6'd41;
        tgt_valid_i = 1'b1;
        capture(12, -1, 0);
        check("pend_code3",   64'(c_code[3]), 64'd30);
        check("pend_code4",   64'(c_code[4]), 64'd32);
        check("pend_code5",   64'(c_code[5]), 64'd32);
        check("pend_ready11", 64'(c_ready[11]), 64'd0);
        check("pend_done12",  64'(c_done[12]), 64'd1);
        check("pend_ready12", 64'(c_ready[12]), 64'd1);
        tick();               // pending 41 transfers on this edge
        tgt_valid_i = 1'b0;

        // 32 -> 41: 36, 40, 41 at 4, 16, 28; done at 36.
        capture(37, -1, 0);
        check("up_code3",   64'(c_code[3]), 64'd32);
        check("up_code4",   64'(c_code[4]), 64'd36);
        check("up_therm4",  64'(c_therm[4]), 64'h0000_000F_FFFF_FFFF);
        check("up_code15",  64'(c_code[15]), 64'd36);
        check("up_code16",  64'(c_code[16]), 64'd40);
        check("up_therm16", 64'(c_therm[16]), 64'h0000_00FF_FFFF_FFFF);
        check("up_code28",  64'(c_code[28]), 64'd41);
        check("up_therm28", 64'(c_therm[28]), 64'h0000_01FF_FFFF_FFFF);
        check("up_busy35",  64'(c_busy[35]), 64'd1);
        check("up_done35",  64'(c_done[35]), 64'd0);
        check("up_done36",  64'(c_done[36]), 64'd1);
        check("up_ready36", 64'(c_ready[36]), 64'd1);
        check("up_done37",  64'(c_done[37]), 64'd0);

        // 41 -> 32: 37, 33, 32; done at 36.
        accept(6'd32);
        capture(36, -1, 0);
        check("back_code4",  64'(c_code[4]), 64'd37);
        check("back_code16", 64'(c_code[16]), 64'd33);
        check("back_code28", 64'(c_code[28]), 64'd32);
        check("back_done36", 64'(c_done[36]), 64'd1);

        // 32 -> 0 with 5 frozen edges inside the first SETTLE.
        accept(6'd0);
        capture(102, 6, 5);
        check("frz_code4",   64'(c_code[4]), 64'd28);
        check("frz_therm4",  64'(c_therm[4]), 64'h0000_0000_0FFF_FFFF);
        check("frz_busy11",  64'(c_busy[11]), 64'd1);
        check("frz_code16",  64'(c_code[16]), 64'd28);
        check("frz_code20",  64'(c_code[20]), 64'd28);
        check("frz_code21",  64'(c_code[21]), 64'd24);
        check("frz_code92",  64'(c_code[92]), 64'd4);
        check("frz_code93",  64'(c_code[93]), 64'd0);
        check("frz_done96",  64'(c_done[96]), 64'd0);
        check("frz_done100", 64'(c_done[100]), 64'd0);
        check("frz_done101", 64'(c_done[101]), 64'd1);
        check("frz_code101", 64'(c_code[101]), 64'd0);
        check("frz_therm101", 64'(c_therm[101]), 64'd0);
        check("frz_done102", 64'(c_done[102]), 64'd0);

        // 0 -> 63, reset asynchronously once code_o is 40.
        accept(6'd63);
        capture(113, -1, 0);
        check("top_code111", 64'(c_code[111]), 64'd36);
        check("top_code112", 64'(c_code[112]), 64'd40);
        check("top_busy113", 64'(c_busy[113]), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_code",  64'(code_o), 64'd32);
        check("arst_therm", 64'(therm_o), 64'h0000_0000_FFFF_FFFF);
        check("arst_busy",  64'(busy_o), 64'd0);
        check("arst_ready", 64'(tgt_ready_o), 64'd1);
        check("arst_done",  64'(done_o), 64'd0);
        tgt_i       = 6'd33;
        tgt_valid_i = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();               // first edge after release transfers 33
        tgt_valid_i = 1'b0;
        check("post_busy0", 64'(busy_o), 64'd1);
        capture(12, -1, 0);
        check("post_code3",  64'(c_code[3]), 64'd32);
        check("post_code4",  64'(c_code[4]), 64'd33);
        check("post_therm4", 64'(c_therm[4]), 64'h0000_0001_FFFF_FFFF);
        check("post_done12", 64'(c_done[12]), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
